// File: rtl/voice_scheduler.sv
// Shares one waveform-lookup unit across three chord voices: one lookup per enabled
// voice per start pulse, each returned sample scaled by 1/4 and summed into a 16-bit mix.
module voice_scheduler #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               generate_next_sample,
  input  logic [2:0]         voice_en,
  input  logic               mute,
  input  logic               clear_err,
  input  logic               lookup_ack,
  input  logic signed [15:0] lookup_sample,
  output logic               lookup_req,
  output logic [1:0]         lookup_voice,
  output logic signed [15:0] mix_out,
  output logic               mix_valid,
  output logic [47:0]        voice_samples,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int DATA_W = 16;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_VOICE, S_DONE} state_t;

  state_t                    state, state_d;
  logic [1:0]                idx, idx_d;
  logic [7:0]                wait_cnt, cnt_d;
  logic [2:0]                en_lat, en_d;
  logic                      mute_lat, mute_d;
  logic signed [DATA_W-1:0]  acc, acc_d;
  logic signed [DATA_W-1:0]  mix_d;
  logic [47:0]               samples_d;
  logic                      mix_vld_d, req_d, set_ovr, set_to, advance;
  logic [1:0]                voice_d;

  // Each term is at most 1/4 full scale, so three of them never overflow 16 bits.
  function automatic logic signed [DATA_W-1:0] scale_term(input logic signed [DATA_W-1:0] s);
    return s >>> 2;
  endfunction

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = wait_cnt;
    en_d      = en_lat;
    mute_d    = mute_lat;
    acc_d     = acc;
    mix_d     = mix_out;
    samples_d = voice_samples;
    mix_vld_d = 1'b0;
    set_ovr   = 1'b0;
    set_to    = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (generate_next_sample) begin
          state_d = S_VOICE;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          en_d    = voice_en;
          mute_d  = mute;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VOICE: begin
        set_ovr = generate_next_sample;
        if (!en_lat[idx]) begin
          advance = 1'b1;
        end else if (lookup_req && lookup_ack) begin
          advance = 1'b1;
          acc_d   = acc + scale_term(lookup_sample);
          case (idx)
            2'd0:    samples_d[47:32] = lookup_sample;
            2'd1:    samples_d[31:16] = lookup_sample;
            default: samples_d[15:0]  = lookup_sample;
          endcase
        end else if (wait_cnt == TO_LAST) begin
          advance = 1'b1;
          set_to  = 1'b1;
        end else begin
          cnt_d = wait_cnt + 8'd1;
        end
        if (advance) begin
          cnt_d = 8'd0;
          if (idx == 2'd2) begin
            state_d   = S_DONE;
            mix_vld_d = 1'b1;
            mix_d     = mute_lat ? '0 : acc_d;
          end else begin
            idx_d = idx + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Request is registered, so it is derived from where the sequence goes next.
    req_d   = (state_d == S_VOICE) && en_d[idx_d];
    voice_d = (state_d == S_VOICE) ? idx_d : 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      wait_cnt      <= 8'd0;
      en_lat        <= 3'd0;
      mute_lat      <= 1'b0;
      acc           <= '0;
      mix_out       <= '0;
      mix_valid     <= 1'b0;
      voice_samples <= '0;
      lookup_req    <= 1'b0;
      lookup_voice  <= 2'd0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      wait_cnt      <= cnt_d;
      en_lat        <= en_d;
      mute_lat      <= mute_d;
      acc           <= acc_d;
      mix_out       <= mix_d;
      mix_valid     <= mix_vld_d;
      voice_samples <= samples_d;
      lookup_req    <= req_d;
      lookup_voice  <= voice_d;
      overrun       <= set_ovr | (overrun & ~clear_err);
      timeout_err   <= set_to | (timeout_err & ~clear_err);
    end
  end

  assign busy = (state == S_VOICE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a combinational lookup responder whose
// per-voice samples and stall mask are set by each test.
module tb_voice_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               generate_next_sample;
  logic [2:0]         voice_en;
  logic               mute;
  logic               clear_err;
  logic               lookup_ack;
  logic signed [15:0] lookup_sample;
  logic               lookup_req;
  logic [1:0]         lookup_voice;
  logic signed [15:0] mix_out;
  logic               mix_valid;
  logic [47:0]        voice_samples;
  logic               busy;
  logic               overrun;
  logic               timeout_err;

  logic [15:0] samp [0:3];
  logic [3:0]  stall;
  logic [2:0]  req_seen;
  int          checks = 0;
  int          failures = 0;
  int          lat;

  voice_scheduler #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .generate_next_sample(generate_next_sample),
    .voice_en(voice_en), .mute(mute), .clear_err(clear_err),
    .lookup_ack(lookup_ack), .lookup_sample(lookup_sample),
    .lookup_req(lookup_req), .lookup_voice(lookup_voice),
    .mix_out(mix_out), .mix_valid(mix_valid), .voice_samples(voice_samples),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    lookup_ack    = lookup_req && !stall[lookup_voice];
    lookup_sample = samp[lookup_voice];
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle; lat = cycle index (T+k) where mix_valid appears, -1 if never.
  // ovr_k != 0 injects a second start pulse in cycle T+ovr_k.
  task automatic run_seq(input int ovr_k, output int lat_o);
    lat_o = -1;
    req_seen = 3'b000;
    generate_next_sample = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      generate_next_sample = (k == ovr_k);
      if (k == ovr_k) chk("busy_mid", {47'd0, busy}, 48'd1);
      if (lookup_req) req_seen[lookup_voice] = 1'b1;
      if (mix_valid) begin
        lat_o = k;
        break;
      end
    end
    generate_next_sample = 1'b0;
  endtask

  task automatic set_samples(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    samp[0] = a; samp[1] = b; samp[2] = c; samp[3] = 16'h0000;
  endtask

  initial begin
    int mv_cnt;
    reset = 1'b0;
    generate_next_sample = 1'b0;
    voice_en = 3'b111;
    mute = 1'b0;
    clear_err = 1'b0;
    stall = 4'b0000;
    set_samples(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_mix", {32'd0, mix_out}, 48'd0);
    chk("rst_req", {47'd0, lookup_req}, 48'd0);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic mix of positive, positive and negative samples
    set_samples(16'h4000, 16'h2000, 16'hC000);
    run_seq(0, lat);
    chk("t1_lat", 48'(lat), 48'd4);
    chk("t1_mix", {32'd0, mix_out}, 48'h0800);
    chk("t1_vs", voice_samples, 48'h4000_2000_C000);
    chk("t1_busy_done", {47'd0, busy}, 48'd0);
    @(negedge clk);
    chk("t1_mv_pulse", {47'd0, mix_valid}, 48'd0);
    chk("t1_hold", {32'd0, mix_out}, 48'h0800);

    // Full-scale extremes
    set_samples(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_seq(0, lat);
    chk("t2_max", {32'd0, mix_out}, 48'h5FFD);
    set_samples(16'h8000, 16'h8000, 16'h8000);
    run_seq(0, lat);
    chk("t2_min", {32'd0, mix_out}, 48'hA000);

    // Only voice 1 enabled
    voice_en = 3'b010;
    set_samples(16'h1234, 16'h0400, 16'h5678);
    run_seq(0, lat);
    chk("t3_lat", 48'(lat), 48'd4);
    chk("t3_mix", {32'd0, mix_out}, 48'h0100);
    chk("t3_req", {45'd0, req_seen}, 48'b010);
    chk("t3_vs", voice_samples, 48'h8000_0400_8000);

    // Mute latched at start
    voice_en = 3'b111;
    mute = 1'b1;
    set_samples(16'h1111, 16'h2222, 16'h3333);
    run_seq(0, lat);
    mute = 1'b0;
    chk("t5_lat", 48'(lat), 48'd4);
    chk("t5_mix", {32'd0, mix_out}, 48'h0000);
    chk("t5_vs", voice_samples, 48'h1111_2222_3333);

    // Voice 1 never acked; extra start during the stall
    stall = 4'b0010;
    set_samples(16'h0100, 16'h7777, 16'h0200);
    run_seq(5, lat);
    stall = 4'b0000;
    chk("t4_lat", 48'(lat), 48'd18);
    chk("t4_mix", {32'd0, mix_out}, 48'h00C0);
    chk("t4_vs", voice_samples, 48'h0100_2222_0200);
    chk("t4_to", {47'd0, timeout_err}, 48'd1);
    chk("t4_ovr", {47'd0, overrun}, 48'd1);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t4_clr_to", {47'd0, timeout_err}, 48'd0);
    chk("t4_clr_ovr", {47'd0, overrun}, 48'd0);

    // Reset while voice 1 is stalled
    stall = 4'b0010;
    set_samples(16'h4444, 16'h5555, 16'h6666);
    generate_next_sample = 1'b1;
    @(negedge clk);
    generate_next_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_req", {46'd0, lookup_req, lookup_voice}, 48'b101);
    reset = 1'b0;
    #1;
    chk("t6_mix", {32'd0, mix_out}, 48'd0);
    chk("t6_vs", voice_samples, 48'd0);
    chk("t6_req", {47'd0, lookup_req}, 48'd0);
    chk("t6_voice", {46'd0, lookup_voice}, 48'd0);
    chk("t6_busy", {47'd0, busy}, 48'd0);
    chk("t6_mv", {47'd0, mix_valid}, 48'd0);
    chk("t6_flags", {46'd0, overrun, timeout_err}, 48'd0);
    @(negedge clk);
    reset = 1'b1;
    stall = 4'b0000;
    mv_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (mix_valid) mv_cnt++;
    end
    chk("t6_no_mix", 48'(mv_cnt), 48'd0);
    chk("t6_idle_busy", {47'd0, busy}, 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
